// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two WIDTH-bit operands through one 4-bit ripple adder, one nibble per clock, LSB first.
// A start/busy/done handshake accepts operands; the last result is held until the next completes.

module ripple_carry_adder_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] a_reg, b_reg, shadow;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;
    logic [IDX_W+1:0] nib_base;
    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic             accept;

    assign nib_base = {idx, 2'b00};
    assign accept   = start && ((state == IDLE) || (state == DONE));

    ripple_carry_adder_4_bit u_adder (
        .a    (a_reg[nib_base +: 4]),
        .b    (b_reg[nib_base +: 4]),
        .cin  (carry_reg),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (idx == LAST_IDX) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            shadow    <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                carry_reg <= carry_in;
                idx       <= '0;
            end else if (state == RUN) begin
                shadow[nib_base +: 4] <= nib_sum;
                carry_reg             <= nib_cout;
                // Final nibble bypasses the shadow so the result lands on the DONE-entry edge.
                if (idx == LAST_IDX) begin
                    sum       <= {nib_sum, shadow[WIDTH-5:0]};
                    carry_out <= nib_cout;
                    overflow  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                 (nib_sum[3] != a_reg[WIDTH-1]);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl: transaction-level model compared every cycle,
// plus directed vectors with hand-computed results.

module tb_nibble_serial_adder_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         busy, done, carry_out, overflow;
    logic [W-1:0] sum;

    int n_tests = 0;
    int n_fail  = 0;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction model: an accepted operation finishes NIB edges after acceptance.
    bit           mvalid = 0;
    int           edge_n = 0;
    int           fin = -100;
    logic [W:0]   pend;
    logic         pend_o;
    logic         exp_busy = 0, exp_done = 0, exp_c = 0, exp_o = 0;
    logic [W-1:0] exp_sum = '0;

    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            mvalid   = 1;
            exp_busy = 0;
            exp_done = 0;
            exp_sum  = '0;
            exp_c    = 0;
            exp_o    = 0;
            fin      = -100;
        end else begin
            automatic logic was_busy = exp_busy;
            exp_done = (edge_n == fin);
            if (edge_n == fin) begin
                exp_sum = pend[W-1:0];
                exp_c   = pend[W];
                exp_o   = pend_o;
            end
            if (!was_busy && start) begin
                pend     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
                pend_o   = (a[W-1] == b[W-1]) && (pend[W-1] != a[W-1]);
                fin      = edge_n + NIB;
                exp_busy = 1;
            end else begin
                exp_busy = (edge_n < fin);
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("sum", sum, exp_sum);
            check("carry_out", carry_out, exp_c);
            check("overflow", overflow, exp_o);
        end
    end

    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                         input logic [W-1:0] es, input logic ec, input logic eo,
                         input string nm);
        int nb;
        bit got;
        @(posedge clk); #1;
        start = 1; a = ai; b = bi; carry_in = ci;
        @(posedge clk); #1;
        start = 0;
        nb  = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) got = 1;
        end
        check({nm, "_done_seen"}, got, 1);
        check({nm, "_busy_cycles"}, nb, NIB);
        check({nm, "_sum"}, sum, es);
        check({nm, "_carry"}, carry_out, ec);
        check({nm, "_ovf"}, overflow, eo);
    endtask

    initial begin
        int nd, last;
        logic [W:0] full;
        logic [W-1:0] ra, rb;
        logic rc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_carry", carry_out, 0);
        check("rst_ovf", overflow, 0);
        reset = 0;

        do_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, "basic");
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "sovf");
        do_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, "cin_only");

        // start and operand changes during RUN are ignored
        @(posedge clk); #1;
        start = 1; a = 16'h00F0; b = 16'h0010; carry_in = 0;
        @(posedge clk); #1;
        a = 16'hFFFF;
        @(negedge clk);
        check("ign_sum_held", sum, 16'h0001);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("ign_done_count", nd, 1);
        check("ign_sum", sum, 16'h0100);

        // back-to-back with start held high
        nd = 0;
        last = -1;
        @(posedge clk); #1;
        start = 1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
            @(negedge clk);
            if (done) begin
                if (last >= 0) check("b2b_interval", i - last, NIB + 1);
                last = i;
                nd++;
            end
        end
        check("b2b_count", nd >= 5, 1);
        start = 0;
        repeat (8) @(posedge clk);

        // reset one cycle into RUN aborts the operation
        #1;
        start = 1; a = 16'h1234; b = 16'h4321; carry_in = 0;
        @(posedge clk); #1;
        start = 0; reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_carry", carry_out, 0);
        check("abort_ovf", overflow, 0);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);
        do_op(16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0, 1'b0, "post_abort");

        // random operands
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            do_op(ra, rb, rc, full[W-1:0], full[W],
                  (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
